// File: rtl/vc_crossbar3_alloc_if.sv
// Handshake bundle between the 3x3 switch allocator and its inputs/outputs.
// master = flit sources and downstream ready; slave = the allocator.
interface vc_crossbar3_alloc_if;
   logic [2:0] in_val;
   logic [5:0] in_dest;
   logic [2:0] in_tail;
   logic [2:0] in_rdy;
   logic [2:0] out_val;
   logic [2:0] out_rdy;
   logic [1:0] sel0;
   logic [1:0] sel1;
   logic [1:0] sel2;

   modport master (
      output in_val, in_dest, in_tail, out_rdy,
      input  in_rdy, out_val, sel0, sel1, sel2
   );

   modport slave (
      input  in_val, in_dest, in_tail, out_rdy,
      output in_rdy, out_val, sel0, sel1, sel2
   );
endinterface

// File: rtl/vc_crossbar3_alloc.sv
// Switch allocator for a 3x3 crossbar: per-output round-robin arbitration
// with packet locking from head to tail flit. Grants are combinational.
//
// Per-output lock state:
//   state     | meaning
//   ST_OPEN   | output free; arbitrate round-robin starting at ptr
//   ST_LOCKED | mid-packet; only owner may be granted until its tail transfers
module vc_crossbar3_alloc (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cur_sd,
   vc_crossbar3_alloc_if.slave   bus
);

   typedef enum logic {
      ST_OPEN   = 1'b0,
      ST_LOCKED = 1'b1
   } lock_state_e;

   lock_state_e state_q [3];
   lock_state_e state_d [3];
   logic [1:0]  ptr_q   [3];
   logic [1:0]  ptr_d   [3];
   logic [1:0]  owner_q [3];
   logic [1:0]  owner_d [3];

   logic [1:0]  dest    [3];
   logic [2:0]  req     [3];
   logic [2:0]  gnt_val;
   logic [1:0]  gnt_idx [3];
   logic [1:0]  sel     [3];
   logic [2:0]  xfer;

   // Security label is carried for information-flow tooling only.
   logic unused_cur_sd;
   assign unused_cur_sd = cur_sd;

   function automatic logic [1:0] inc3(input logic [1:0] v);
      return (v == 2'd2) ? 2'd0 : v + 2'd1;
   endfunction

   // req[o][i]: input i presents a flit for output o; dest 3 matches nothing.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         dest[i] = bus.in_dest[2*i +: 2];
      end
      for (int o = 0; o < 3; o++) begin
         req[o] = 3'b000;
         for (int i = 0; i < 3; i++) begin
            req[o][i] = bus.in_val[i] && (dest[i] == 2'(o));
         end
      end
   end

   always_comb begin
      logic [1:0] cand;
      cand    = 2'd0;
      gnt_val = 3'b000;
      for (int o = 0; o < 3; o++) begin
         gnt_idx[o] = 2'd0;
         if (state_q[o] == ST_LOCKED) begin
            gnt_val[o] = req[o][owner_q[o]];
            gnt_idx[o] = owner_q[o];
         end else begin
            cand = ptr_q[o];
            for (int k = 0; k < 3; k++) begin
               if (!gnt_val[o] && req[o][cand]) begin
                  gnt_val[o] = 1'b1;
                  gnt_idx[o] = cand;
               end
               cand = inc3(cand);
            end
         end
      end
   end

   // A stalled owner keeps sel parked on itself so the datapath does not glitch.
   always_comb begin
      bus.out_val = 3'b000;
      bus.in_rdy  = 3'b000;
      xfer        = 3'b000;
      for (int o = 0; o < 3; o++) begin
         sel[o] = 2'd0;
      end
      if (!reset) begin
         for (int o = 0; o < 3; o++) begin
            bus.out_val[o] = gnt_val[o];
            xfer[o]        = gnt_val[o] && bus.out_rdy[o];
            if (gnt_val[o]) begin
               sel[o] = gnt_idx[o];
            end else if (state_q[o] == ST_LOCKED) begin
               sel[o] = owner_q[o];
            end
         end
         for (int i = 0; i < 3; i++) begin
            if (dest[i] != 2'd3) begin
               bus.in_rdy[i] = gnt_val[dest[i]] && (gnt_idx[dest[i]] == 2'(i))
                               && bus.out_rdy[dest[i]];
            end
         end
      end
   end

   assign bus.sel0 = sel[0];
   assign bus.sel1 = sel[1];
   assign bus.sel2 = sel[2];

   always_comb begin
      for (int o = 0; o < 3; o++) begin
         state_d[o] = state_q[o];
         ptr_d[o]   = ptr_q[o];
         owner_d[o] = owner_q[o];
         if (xfer[o]) begin
            if (bus.in_tail[gnt_idx[o]]) begin
               state_d[o] = ST_OPEN;
               ptr_d[o]   = inc3(gnt_idx[o]);
            end else begin
               state_d[o] = ST_LOCKED;
               owner_d[o] = gnt_idx[o];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int o = 0; o < 3; o++) begin
            state_q[o] <= ST_OPEN;
            ptr_q[o]   <= 2'd0;
            owner_q[o] <= 2'd0;
         end
      end else begin
         for (int o = 0; o < 3; o++) begin
            state_q[o] <= state_d[o];
            ptr_q[o]   <= ptr_d[o];
            owner_q[o] <= owner_d[o];
         end
      end
   end

endmodule

// File: tb/tb_vc_crossbar3_alloc.sv
// Self-checking bench for vc_crossbar3_alloc: directed scenarios then random
// traffic, every cycle compared against a behavioural allocation model.
module tb_vc_crossbar3_alloc;

   logic clk = 1'b0;
   logic reset;
   logic cur_sd;

   always #5 clk = ~clk;

   vc_crossbar3_alloc_if bus ();

   vc_crossbar3_alloc dut (
      .clk    (clk),
      .reset  (reset),
      .cur_sd (cur_sd),
      .bus    (bus.slave)
   );

   int n_cmp = 0;
   int n_err = 0;

   // model state: per output round-robin pointer, lock flag and owner
   int m_ptr   [3];
   int m_lock  [3];
   int m_owner [3];
   int e_gnt   [3];
   int e_sel   [3];
   logic [2:0] e_rdy;
   logic [2:0] e_oval;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   function automatic int dest_of(input int i);
      return int'(bus.in_dest[2*i +: 2]);
   endfunction

   function automatic bit requests(input int i, input int o);
      return bus.in_val[i] && (dest_of(i) == o);
   endfunction

   function automatic void model_eval();
      for (int o = 0; o < 3; o++) begin
         e_gnt[o] = -1;
         if (!reset) begin
            if (m_lock[o] != 0) begin
               if (requests(m_owner[o], o)) e_gnt[o] = m_owner[o];
            end else begin
               for (int k = 0; k < 3; k++) begin
                  int i;
                  i = (m_ptr[o] + k) % 3;
                  if (e_gnt[o] < 0 && requests(i, o)) e_gnt[o] = i;
               end
            end
         end
         e_oval[o] = (e_gnt[o] >= 0);
         if (e_gnt[o] >= 0)                    e_sel[o] = e_gnt[o];
         else if (!reset && m_lock[o] != 0)    e_sel[o] = m_owner[o];
         else                                  e_sel[o] = 0;
      end
      for (int i = 0; i < 3; i++) begin
         int d;
         d = dest_of(i);
         e_rdy[i] = 1'b0;
         if (!reset && d < 3) e_rdy[i] = (e_gnt[d] == i) && bus.out_rdy[d];
      end
   endfunction

   function automatic void model_update();
      for (int o = 0; o < 3; o++) begin
         if (reset) begin
            m_ptr[o] = 0; m_lock[o] = 0; m_owner[o] = 0;
         end else if (e_gnt[o] >= 0 && bus.out_rdy[o]) begin
            if (bus.in_tail[e_gnt[o]]) begin
               m_lock[o] = 0;
               m_ptr[o]  = (e_gnt[o] + 1) % 3;
            end else begin
               m_lock[o]  = 1;
               m_owner[o] = e_gnt[o];
            end
         end
      end
   endfunction

   // drive away from the active edge and compare against the model
   task automatic apply(input logic [2:0] v, input logic [5:0] d, input logic [2:0] t,
                        input logic [2:0] ordy, input logic rst);
      @(negedge clk);
      bus.in_val  = v;
      bus.in_dest = d;
      bus.in_tail = t;
      bus.out_rdy = ordy;
      reset       = rst;
      #1;
      model_eval();
      chk("in_rdy",  32'(bus.in_rdy),  32'(e_rdy));
      chk("out_val", 32'(bus.out_val), 32'(e_oval));
      chk("sel0",    32'(bus.sel0),    32'(e_sel[0]));
      chk("sel1",    32'(bus.sel1),    32'(e_sel[1]));
      chk("sel2",    32'(bus.sel2),    32'(e_sel[2]));
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
   endtask

   task automatic run(input logic [2:0] v, input logic [5:0] d, input logic [2:0] t,
                      input logic [2:0] ordy, input logic rst);
      apply(v, d, t, ordy, rst);
      tick();
   endtask

   int rr_exp [4] = '{0, 1, 2, 0};

   initial begin
      cur_sd      = 1'b0;
      reset       = 1'b1;
      bus.in_val  = 3'b000;
      bus.in_dest = 6'b0;
      bus.in_tail = 3'b000;
      bus.out_rdy = 3'b000;
      for (int o = 0; o < 3; o++) begin
         m_ptr[o] = 0; m_lock[o] = 0; m_owner[o] = 0;
      end

      // reset with everything requesting
      apply(3'b111, 6'b10_01_00, 3'b111, 3'b111, 1'b1);
      chk("rst_in_rdy",  32'(bus.in_rdy),  32'd0);
      chk("rst_out_val", 32'(bus.out_val), 32'd0);
      tick();
      run(3'b111, 6'b10_01_00, 3'b111, 3'b111, 1'b1);

      // round robin on output 1
      for (int n = 0; n < 4; n++) begin
         apply(3'b111, 6'b01_01_01, 3'b111, 3'b111, 1'b0);
         chk("rr_sel1", 32'(bus.sel1), 32'(rr_exp[n]));
         tick();
      end

      // packet lock: input 2 head, body (input 0 contending), stall, tail
      run(3'b100, 6'b00_00_00, 3'b000, 3'b111, 1'b0);
      apply(3'b101, 6'b00_00_00, 3'b000, 3'b111, 1'b0);
      chk("lock_body_sel0", 32'(bus.sel0), 32'd2);
      tick();
      apply(3'b001, 6'b00_00_00, 3'b000, 3'b111, 1'b0);
      chk("lock_stall_oval0", 32'(bus.out_val[0]), 32'd0);
      chk("lock_stall_rdy0",  32'(bus.in_rdy[0]),  32'd0);
      chk("lock_stall_sel0",  32'(bus.sel0),       32'd2);
      tick();
      apply(3'b101, 6'b00_00_00, 3'b100, 3'b111, 1'b0);
      chk("lock_tail_rdy", 32'(bus.in_rdy), 32'b100);
      tick();
      apply(3'b001, 6'b00_00_00, 3'b001, 3'b111, 1'b0);
      chk("after_tail_rdy0", 32'(bus.in_rdy[0]), 32'd1);
      tick();

      // backpressure on output 2
      for (int n = 0; n < 4; n++) begin
         apply(3'b010, 6'b00_10_00, 3'b010, 3'b011, 1'b0);
         chk("bp_oval2", 32'(bus.out_val[2]), 32'd1);
         chk("bp_rdy1",  32'(bus.in_rdy[1]),  32'd0);
         tick();
      end
      apply(3'b010, 6'b00_10_00, 3'b010, 3'b111, 1'b0);
      chk("bp_release_rdy1", 32'(bus.in_rdy[1]), 32'd1);
      tick();

      // parallel transfers and an invalid destination
      apply(3'b111, 6'b01_00_10, 3'b111, 3'b111, 1'b0);
      chk("par_rdy",  32'(bus.in_rdy), 32'b111);
      chk("par_sel0", 32'(bus.sel0),   32'd1);
      chk("par_sel1", 32'(bus.sel1),   32'd2);
      chk("par_sel2", 32'(bus.sel2),   32'd0);
      tick();
      apply(3'b001, 6'b00_00_11, 3'b001, 3'b111, 1'b0);
      chk("inv_oval", 32'(bus.out_val), 32'd0);
      tick();

      // reset mid-packet on output 1
      run(3'b001, 6'b00_00_01, 3'b000, 3'b111, 1'b0);
      run(3'b001, 6'b00_00_01, 3'b000, 3'b111, 1'b1);
      apply(3'b010, 6'b00_01_00, 3'b010, 3'b111, 1'b0);
      chk("post_rst_rdy1", 32'(bus.in_rdy[1]), 32'd1);
      chk("post_rst_sel1", 32'(bus.sel1),      32'd1);
      tick();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         logic [5:0] d;
         for (int i = 0; i < 3; i++) d[2*i +: 2] = 2'($urandom_range(0, 3));
         run(3'($urandom), d, 3'($urandom), 3'($urandom | $urandom),
             ($urandom_range(0, 99) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vc_crossbar3_alloc.md
Name: vc_crossbar3_alloc

Overview:
- Switch allocator that sequences a 3-input, 3-output crossbar (`vc_Crossbar3`) with val/rdy handshakes on both sides.
- Arbitrates per output between inputs that target it, using a round-robin pointer per output.
- Locks an output to one input for the whole of a multi-flit packet, from head flit to tail flit.
- Drives the crossbar's `sel0`/`sel1`/`sel2`, and produces `in_rdy` and `out_val`; datapath width is entirely in the crossbar.

Parameters:
- None. Port count is fixed at 3x3 to match `vc_Crossbar3`.

Ports:
- `clk`  input  1  clock
- `reset`  input  1  synchronous, active-high reset
- `cur_sd`  input  1  security-domain label {L}. All other ports are {Domain cur_sd}. Must be stable during operation; no logic depends on it.
- `in_val`  input  3  bit i: input i presents a flit
- `in_dest`  input  6  bits [2i+1:2i]: destination output of input i. Value 3 is invalid.
- `in_tail`  input  3  bit i: the flit on input i is the last flit of its packet
- `in_rdy`  output  3  bit i: input i's flit transfers this cycle if `in_val[i]`
- `out_val`  output  3  bit o: output o carries a valid flit
- `out_rdy`  input  3  bit o: downstream of output o accepts
- `sel0`, `sel1`, `sel2`  output  2 each  crossbar select for outputs 0/1/2; value = granted input index

Behaviour:
- **State per output o:**
  - `ptr[o]` (2 bits, 0..2): highest-priority input.
  - `lock[o]` (1 bit) and `owner[o]` (2 bits).
- **Reset:**
  - While `reset` is high: all `ptr` = 0, `lock` = 0, `owner` = 0.
  - Outputs are forced to `in_rdy` = 0, `out_val` = 0, `sel*` = 0.
  - Reset mid-packet abandons the packet; the lock is cleared.
- **Request:** `req[i][o]` = `in_val[i]` && (`in_dest[i]` == o).
  - `in_dest` = 3 never requests; `in_rdy[i]` = 0 for that input.
- **Grant (combinational, same cycle):**
  - If `lock[o]`: the grant goes to `owner[o]` only, and only if `req[owner][o]`; otherwise no grant.
  - If unlocked: the first requesting input found scanning `ptr[o]`, `ptr[o]`+1, `ptr[o]`+2 (mod 3).
- **Outputs:**
  - `out_val[o]` = output o has a grant.
  - `sel_o` = granted input. When there is no grant: `owner[o]` if locked, else 0.
  - `in_rdy[i]` = input i is granted by its destination o && `out_rdy[o]`.
  - Each input requests at most one output, so there are never double grants.
  - Latency: zero cycles, val->rdy is combinational. `out_rdy` -> `in_rdy` is a combinational path; there is no `in_val` -> `in_val` loop.
- **Transfer on output o:** `out_val[o]` && `out_rdy[o]`. At the clock edge:
  - Non-tail flit: `lock[o]` <= 1, `owner[o]` <= granted input. The pointer is unchanged.
  - Tail flit: `lock[o]` <= 0, `ptr[o]` <= (granted+1) mod 3.
  - A single-flit packet (head == tail) never locks.
- **Locked output, owner stalls:**
  - If the owner deasserts `in_val` or changes `in_dest` while `lock[o]`: `out_val[o]` = 0 and `sel` holds `owner`.
  - Other inputs stay blocked until the owner's tail transfers.
- **Backpressure:** granted but `out_rdy` = 0 means no transfer and no state change. The next cycle re-arbitrates identically if unlocked; the pointer is not advanced.
- **Simultaneous events:** all three outputs arbitrate and update independently in the same cycle.

Test Plan:
- **Reset:** assert `reset` with all `in_val` = 1 → `in_rdy` = 000, `out_val` = 000, `sel*` = 0. Release → first grants come from `ptr` = 0.
- **Round-robin:** inputs 0, 1, 2 all send single-flit tails to output 1 with `out_rdy` = 1 continuously → `sel1` sequence is 0, 1, 2, 0; `ptr[1]` follows 1, 2, 0.
- **Packet lock:**
  - Input 2 sends head, body, tail to output 0 while input 0 also requests output 0 → `sel0` = 2 for 3 transfers, then input 0 is granted.
  - Input 2 drops `in_val` for 1 cycle mid-packet → `out_val[0]` = 0 and input 0 is still blocked.
- **Backpressure:** `out_rdy[2]` = 0 for 4 cycles with input 1 requesting output 2 → `out_val[2]` = 1, `in_rdy[1]` = 0, and the grant is unchanged. The transfer happens on the cycle `out_rdy` rises.
- **Parallel and invalid:**
  - Inputs 0→2, 1→0, 2→1 all tails → all three transfer in one cycle, with `sel0` = 1, `sel1` = 2, `sel2` = 0.
  - An input with `in_dest` = 3 → its `in_rdy` = 0 and no `out_val` is raised.
- **Reset mid-packet:** reset after a head flit locks output 1 → after reset, `lock` is cleared and a different input is granted output 1 immediately.
